tx_burst_scheduler: RTL
=======================

# tx_burst_scheduler

Ping-pong scheduler for the double-buffered I2C master transmitter. It sequences the two transmit buffers: fetches words from the data source with a ready/valid handshake, issues per-buffer load and shift strobes, counts bits per word (size) and words per burst (burst), and waits for the slave acknowledge between words. It sits between the control registers (size/burst) and the transmit datapath, replacing ad-hoc buffer sequencing with one owned FSM.

## Interface
- CNT_W, 6: width of size, burst, bit and word counters
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin burst; sampled only in IDLE
- size  in  CNT_W  bits per word, 1..32; 0 treated as 32
- burst  in  CNT_W  words per burst; 0 = empty burst
- data_valid  in  1  source presents next word on the data bus
- ready_data  out  1  request next word; transfer when ready_data & data_valid
- load_buf0, load_buf1  out  1  one-cycle load strobe for buffer 0 / 1
- shift_buf0, shift_buf1  out  1  shift enable, one bit per cycle
- wait_ack  out  1  high while waiting for slave response
- ack_valid  in  1  slave response present
- nack  in  1  with ack_valid: 1 = NACK, 0 = ACK
- busy  out  1  high from first cycle after accepted start until done
- done  out  1  one-cycle pulse at burst end
- err  out  1  valid with done; 1 = aborted
- word_cnt  out  CNT_W  words acknowledged in current burst

## Operation
- States: IDLE, PRIME, SHIFT, ACK, STALL, DONE.
- IDLE: all strobes low. start=1 -> PRIME (burst≠0) or DONE (burst=0). Latch size/burst at start; later changes ignored until next burst.
- PRIME: ready_data=1; on data_valid pulse load_buf0, set full0, cur=0 -> SHIFT.
- SHIFT: shift_buf[cur]=1, bit_cnt increments; at bit_cnt==size-1 clear full[cur], bit_cnt<=0 -> ACK.
- ACK: wait_ack=1. ack_valid&!nack -> word_cnt+1; if word_cnt+1==burst -> DONE(err=0); else if full[!cur] -> cur<=!cur, SHIFT; else STALL. ack_valid&nack -> DONE(err=1).
- STALL: ready_data=1; on data_valid load buf[!cur], cur<=!cur -> SHIFT next cycle.
- Prefetch: in SHIFT and ACK, ready_data=1 when full[!cur]=0 and words_loaded<burst; accepted word loads buf[!cur] (load_buf strobe same cycle as handshake), sets full[!cur], words_loaded+1.
- Never more than two words outstanding; load and shift never target the same buffer in the same cycle.
- DONE: done=1, err per cause, busy=0 -> IDLE next cycle. Clear full flags and counters on entry to IDLE.
- start while busy ignored. Aborted burst discards any prefetched word.

## Timing
- Reset values: state IDLE; ready_data, load_*, shift_*, wait_ack, busy, done, err = 0; word_cnt = 0.
- start at cycle T -> PRIME at T+1 (ready_data high at T+1).
- Handshake at cycle L -> first shift_buf0 at L+1; size consecutive shift cycles; wait_ack at L+1+size.
- ACK accepted at cycle A with next buffer full -> shift of next word at A+1 (zero-bubble).
- Empty burst: start at T -> done at T+1, no ready_data.
- rst mid-burst: all outputs return to reset values asynchronously; no done pulse.
- ack_valid outside ACK ignored. data_valid without ready_data ignored.

## Configuration
- TXSCHED_ACK_TIMEOUT_EN: when defined, an 8-bit counter runs in ACK; 255 cycles without ack_valid -> DONE with err=1. Counter resets on entering ACK. When undefined, ACK waits indefinitely; no counter logic present.

## Test plan
- size=8, burst=3, data_valid always 1, ACK one cycle after wait_ack -> load_buf0, load_buf1, load_buf0 sequence; 24 shift cycles alternating buffers 0/1/0; done with err=0, word_cnt=3.
- size=0, burst=1 -> 32 consecutive shift_buf0 cycles, then wait_ack; done after ACK.
- burst=0, start -> done=1 at T+1, err=0, ready_data never high.
- size=4, burst=2, data_valid withheld 10 cycles after first ACK -> STALL with ready_data=1; second word shifts one cycle after data_valid; done err=0.
- size=8, burst=4, NACK on word 2 -> done err=1, word_cnt=1, no further shifts; rst asserted mid-SHIFT in a rerun -> all outputs 0 immediately.
- With TXSCHED_ACK_TIMEOUT_EN: no ack_valid -> done err=1 exactly 255 cycles after wait_ack rises.

Source files
------------

// File: rtl/tx_burst_scheduler.sv
// tx_burst_scheduler
// Ping-pong buffer scheduler for the double-buffered I2C master transmitter.
// It fetches words over a ready/valid handshake, alternates them between two
// transmit buffers, strobes the per-buffer load and shift enables, counts bits
// per word and words per burst, and waits for the slave acknowledge between
// words. While one buffer shifts, the other is prefetched so that an accepted
// ACK can be followed by the next word without a bubble.
//
// Optional feature: define TXSCHED_ACK_TIMEOUT_EN to abort a burst (err=1)
// after 255 consecutive ACK cycles without a slave response. Without the
// macro, ACK waits indefinitely and no timeout counter exists.

module tx_burst_scheduler #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] size,
   input  logic [CNT_W-1:0] burst,
   input  logic             data_valid,
   output logic             ready_data,
   output logic             load_buf0,
   output logic             load_buf1,
   output logic             shift_buf0,
   output logic             shift_buf1,
   output logic             wait_ack,
   input  logic             ack_valid,
   input  logic             nack,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      SHIFT = 3'd2,
      ACK   = 3'd3,
      STALL = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t           stateQ, stateD;

   // Burst configuration captured when the burst starts
   logic [CNT_W-1:0] lastBitQ, lastBitD;
   logic [CNT_W-1:0] burstQ, burstD;

   // Progress counters
   logic [CNT_W-1:0] bitCntQ, bitCntD;
   logic [CNT_W-1:0] wordCntQ, wordCntD;
   logic [CNT_W-1:0] loadedQ, loadedD;

   // Buffer occupancy, which buffer is current, and the abort cause
   logic             full0Q, full0D;
   logic             full1Q, full1D;
   logic             curQ, curD;
   logic             errQ, errD;

`ifdef TXSCHED_ACK_TIMEOUT_EN
   logic [7:0]       ackWaitQ, ackWaitD;
`endif

   logic [CNT_W-1:0] sizeEff;
   logic             fullOther;
   logic             accept;

   // A programmed size of zero means a full 32-bit word
   assign sizeEff   = (size == '0) ? CNT_W'(32) : size;

   // Occupancy of the buffer that is not currently being shifted
   assign fullOther = curQ ? full0Q : full1Q;

   assign word_cnt  = wordCntQ;
   assign busy      = (stateQ != IDLE) && (stateQ != DONE);

   // Next-state, counter updates and strobes for the whole scheduler
   always_comb begin
      stateD     = stateQ;
      lastBitD   = lastBitQ;
      burstD     = burstQ;
      bitCntD    = bitCntQ;
      wordCntD   = wordCntQ;
      loadedD    = loadedQ;
      full0D     = full0Q;
      full1D     = full1Q;
      curD       = curQ;
      errD       = errQ;
`ifdef TXSCHED_ACK_TIMEOUT_EN
      ackWaitD   = ackWaitQ;
`endif
      ready_data = 1'b0;
      load_buf0  = 1'b0;
      load_buf1  = 1'b0;
      shift_buf0 = 1'b0;
      shift_buf1 = 1'b0;
      wait_ack   = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      accept     = 1'b0;

      // Prefetch into the idle buffer while the current word shifts or waits
      // for its acknowledge; the load always targets the non-current buffer
      // so it can never collide with a shift.
      if ((stateQ == SHIFT) || (stateQ == ACK)) begin
         ready_data = !fullOther && (loadedQ < burstQ);
         accept     = ready_data && data_valid;
         if (accept) begin
            loadedD = loadedQ + CNT_W'(1);
            if (curQ) begin
               load_buf0 = 1'b1;
               full0D    = 1'b1;
            end else begin
               load_buf1 = 1'b1;
               full1D    = 1'b1;
            end
         end
      end

      case (stateQ)
         IDLE: begin
            if (start) begin
               lastBitD = sizeEff - CNT_W'(1);
               burstD   = burst;
               bitCntD  = '0;
               wordCntD = '0;
               loadedD  = '0;
               full0D   = 1'b0;
               full1D   = 1'b0;
               curD     = 1'b0;
               errD     = 1'b0;
               if (burst == '0) begin
                  stateD = DONE;
               end else begin
                  stateD = PRIME;
               end
            end
         end

         PRIME: begin
            ready_data = 1'b1;
            if (data_valid) begin
               load_buf0 = 1'b1;
               full0D    = 1'b1;
               curD      = 1'b0;
               loadedD   = CNT_W'(1);
               bitCntD   = '0;
               stateD    = SHIFT;
            end
         end

         SHIFT: begin
            if (curQ) begin
               shift_buf1 = 1'b1;
            end else begin
               shift_buf0 = 1'b1;
            end
            if (bitCntQ == lastBitQ) begin
               bitCntD = '0;
               if (curQ) begin
                  full1D = 1'b0;
               end else begin
                  full0D = 1'b0;
               end
               stateD = ACK;
`ifdef TXSCHED_ACK_TIMEOUT_EN
               ackWaitD = 8'd0;
`endif
            end else begin
               bitCntD = bitCntQ + CNT_W'(1);
            end
         end

         ACK: begin
            wait_ack = 1'b1;
            if (ack_valid) begin
               if (nack) begin
                  errD   = 1'b1;
                  stateD = DONE;
               end else begin
                  wordCntD = wordCntQ + CNT_W'(1);
                  if ((wordCntQ + CNT_W'(1)) == burstQ) begin
                     errD   = 1'b0;
                     stateD = DONE;
                  end else if (fullOther || accept) begin
                     // A word loaded in this very cycle counts as ready,
                     // otherwise STALL would fetch one word too many.
                     curD    = !curQ;
                     bitCntD = '0;
                     stateD  = SHIFT;
                  end else begin
                     stateD = STALL;
                  end
               end
`ifdef TXSCHED_ACK_TIMEOUT_EN
            end else if (ackWaitQ == 8'd254) begin
               errD   = 1'b1;
               stateD = DONE;
            end else begin
               ackWaitD = ackWaitQ + 8'd1;
`endif
            end
         end

         STALL: begin
            ready_data = 1'b1;
            if (data_valid) begin
               if (curQ) begin
                  load_buf0 = 1'b1;
                  full0D    = 1'b1;
               end else begin
                  load_buf1 = 1'b1;
                  full1D    = 1'b1;
               end
               loadedD = loadedQ + CNT_W'(1);
               curD    = !curQ;
               bitCntD = '0;
               stateD  = SHIFT;
            end
         end

         DONE: begin
            // word_cnt stays visible during the done pulse and is cleared,
            // with any prefetched word, as the scheduler returns to IDLE.
            done     = 1'b1;
            err      = errQ;
            bitCntD  = '0;
            wordCntD = '0;
            loadedD  = '0;
            full0D   = 1'b0;
            full1D   = 1'b0;
            curD     = 1'b0;
            errD     = 1'b0;
            stateD   = IDLE;
         end

         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // State and counter registers, cleared asynchronously by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ   <= IDLE;
         lastBitQ <= '0;
         burstQ   <= '0;
         bitCntQ  <= '0;
         wordCntQ <= '0;
         loadedQ  <= '0;
         full0Q   <= 1'b0;
         full1Q   <= 1'b0;
         curQ     <= 1'b0;
         errQ     <= 1'b0;
`ifdef TXSCHED_ACK_TIMEOUT_EN
         ackWaitQ <= 8'd0;
`endif
      end else begin
         stateQ   <= stateD;
         lastBitQ <= lastBitD;
         burstQ   <= burstD;
         bitCntQ  <= bitCntD;
         wordCntQ <= wordCntD;
         loadedQ  <= loadedD;
         full0Q   <= full0D;
         full1Q   <= full1D;
         curQ     <= curD;
         errQ     <= errD;
`ifdef TXSCHED_ACK_TIMEOUT_EN
         ackWaitQ <= ackWaitD;
`endif
      end
   end

endmodule
